// File: rtl/pe_array_sched_if.sv
// Bundle of host, PE and buffer-manager signals around the PE array scheduler.
// The scheduler side uses the master modport, the host/PE/BM side uses slave.
interface pe_array_sched_if #(
  parameter int NUM_PE         = 4,
  parameter int PE_ID_WIDTH    = 2,
  parameter int RBB_DATA_WIDTH = 32,
  parameter int RBB_ADDR_WIDTH = 12,
  parameter int JOB_CNT_WIDTH  = 16
) ();
  logic                                  host_start;
  logic [JOB_CNT_WIDTH-1:0]              host_num_jobs;
  logic                                  host_busy;
  logic                                  host_done;
  logic                                  host_err;
  logic [NUM_PE-1:0]                     sched2pe_start;
  logic [NUM_PE-1:0]                     pe2sched_done;
  logic [NUM_PE-1:0]                     pe_rbbWrEn;
  logic [NUM_PE*RBB_ADDR_WIDTH-1:0]      pe_rbbWrAddr;
  logic [NUM_PE*RBB_DATA_WIDTH-1:0]      pe_rbbWrDin;
  logic [NUM_PE-1:0]                     pe_rbbWrGnt;
  logic                                  sched2bm_rbbWrEn;
  logic [PE_ID_WIDTH+RBB_ADDR_WIDTH-1:0] sched2bm_rbbWrAddr;
  logic [RBB_DATA_WIDTH-1:0]             sched2bm_rbbWrDin;

  // Write handshake: a PE raises pe_rbbWrEn[i] with Addr/Din and holds all three
  // stable until it sees pe_rbbWrGnt[i] high in the same cycle; the transfer
  // completes on that edge and reaches the BM one cycle later, no back-pressure.
  modport master (
    input  host_start, host_num_jobs, pe2sched_done,
           pe_rbbWrEn, pe_rbbWrAddr, pe_rbbWrDin,
    output host_busy, host_done, host_err, sched2pe_start, pe_rbbWrGnt,
           sched2bm_rbbWrEn, sched2bm_rbbWrAddr, sched2bm_rbbWrDin
  );

  modport slave (
    output host_start, host_num_jobs, pe2sched_done,
           pe_rbbWrEn, pe_rbbWrAddr, pe_rbbWrDin,
    input  host_busy, host_done, host_err, sched2pe_start, pe_rbbWrGnt,
           sched2bm_rbbWrEn, sched2bm_rbbWrAddr, sched2bm_rbbWrDin
  );
endinterface

// File: rtl/pe_array_sched.sv
// Dispatches a batch of jobs onto idle PEs and shares one RBB write port among
// them with a round-robin arbiter that tags each address with the PE index.
module pe_array_sched #(
  parameter int NUM_PE         = 4,
  parameter int PE_ID_WIDTH    = 2,
  parameter int RBB_DATA_WIDTH = 32,
  parameter int RBB_ADDR_WIDTH = 12,
  parameter int JOB_CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  pe_array_sched_if.master      io_bus,
  output logic [1:0]            o_dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_DISPATCH = 2'd1,
    S_DRAIN    = 2'd2,
    S_FINISH   = 2'd3
  } state_t;

  state_t                                r_state, w_next;
  logic [JOB_CNT_WIDTH-1:0]              r_jobs_left, r_num_jobs, r_completed;
  logic [NUM_PE-1:0]                     r_pe_busy, w_start, w_gnt;
  logic [NUM_PE-1:0]                     w_done_ok, w_done_bad;
  logic [PE_ID_WIDTH-1:0]                r_rr, w_win, w_idx, w_fidx;
  logic                                  w_any, w_free_any, w_accept, w_dispatch;
  logic                                  r_busy, r_done, r_err;
  logic                                  r_bm_en;
  logic [PE_ID_WIDTH+RBB_ADDR_WIDTH-1:0] r_bm_addr;
  logic [RBB_DATA_WIDTH-1:0]             r_bm_din;
  logic [RBB_ADDR_WIDTH-1:0]             w_sel_addr;
  logic [RBB_DATA_WIDTH-1:0]             w_sel_din;
  logic [JOB_CNT_WIDTH-1:0]              w_pop;
  logic                                  w_over;

  // Dispatch only looks at registered busy, so a PE finishing this cycle is
  // reused at the earliest in the next one.
  always_comb begin
    w_next     = r_state;
    w_accept   = 1'b0;
    w_dispatch = 1'b0;
    w_start    = '0;
    w_fidx     = '0;
    w_free_any = 1'b0;
    for (int k = NUM_PE - 1; k >= 0; k--) begin
      if (!r_pe_busy[k]) begin
        w_free_any = 1'b1;
        w_fidx     = PE_ID_WIDTH'(k);
      end
    end
    case (r_state)
      S_IDLE: begin
        if (io_bus.host_start) begin
          w_accept = 1'b1;
          w_next   = (io_bus.host_num_jobs == '0) ? S_FINISH : S_DISPATCH;
        end
      end
      S_DISPATCH: begin
        if (r_jobs_left == '0) begin
          w_next = S_DRAIN;
        end else if (w_free_any) begin
          w_dispatch      = 1'b1;
          w_start[w_fidx] = 1'b1;
          if (r_jobs_left == JOB_CNT_WIDTH'(1)) w_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (r_completed == r_num_jobs && r_pe_busy == '0 &&
            io_bus.pe_rbbWrEn == '0 && !r_bm_en)
          w_next = S_FINISH;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_done_ok  = io_bus.pe2sched_done & r_pe_busy;
    w_done_bad = io_bus.pe2sched_done & ~r_pe_busy;
    w_pop      = '0;
    for (int k = 0; k < NUM_PE; k++)
      w_pop = w_pop + JOB_CNT_WIDTH'(w_done_ok[k]);
    w_over = ({1'b0, r_completed} + {1'b0, w_pop}) > {1'b0, r_num_jobs};
  end

  // Round-robin search starting at r_rr; the index wraps because NUM_PE is a power of two.
  always_comb begin
    w_any = 1'b0;
    w_win = '0;
    w_idx = '0;
    w_gnt = '0;
    for (int k = 0; k < NUM_PE; k++) begin
      w_idx = r_rr + PE_ID_WIDTH'(k);
      if (!w_any && io_bus.pe_rbbWrEn[w_idx]) begin
        w_any = 1'b1;
        w_win = w_idx;
      end
    end
    if (reset) w_any = 1'b0;
    if (w_any) w_gnt[w_win] = 1'b1;
    w_sel_addr = io_bus.pe_rbbWrAddr[32'(w_win)*RBB_ADDR_WIDTH +: RBB_ADDR_WIDTH];
    w_sel_din  = io_bus.pe_rbbWrDin[32'(w_win)*RBB_DATA_WIDTH +: RBB_DATA_WIDTH];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_jobs_left <= '0;
      r_num_jobs  <= '0;
      r_completed <= '0;
      r_pe_busy   <= '0;
      r_rr        <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_bm_en     <= 1'b0;
      r_bm_addr   <= '0;
      r_bm_din    <= '0;
    end else begin
      r_state   <= w_next;
      r_pe_busy <= (r_pe_busy & ~w_done_ok) | w_start;
      r_done    <= (r_state == S_FINISH);
      if (w_accept) begin
        r_jobs_left <= io_bus.host_num_jobs;
        r_num_jobs  <= io_bus.host_num_jobs;
        r_completed <= '0;
        r_err       <= 1'b0;
        r_busy      <= 1'b1;
      end else begin
        if (w_dispatch) r_jobs_left <= r_jobs_left - JOB_CNT_WIDTH'(1);
        if (!w_over) r_completed <= r_completed + w_pop;
        if (w_done_bad != '0 || w_over) r_err <= 1'b1;
      end
      if (r_state == S_FINISH) r_busy <= 1'b0;
      if (w_accept) r_rr <= '0;
      else if (w_any) r_rr <= w_win + PE_ID_WIDTH'(1);
      r_bm_en <= w_any;
      if (w_any) begin
        r_bm_addr <= {w_win, w_sel_addr};
        r_bm_din  <= w_sel_din;
      end
    end
  end

  assign io_bus.host_busy          = r_busy;
  assign io_bus.host_done          = r_done;
  assign io_bus.host_err           = r_err;
  assign io_bus.sched2pe_start     = w_start;
  assign io_bus.pe_rbbWrGnt        = w_gnt;
  assign io_bus.sched2bm_rbbWrEn   = r_bm_en;
  assign io_bus.sched2bm_rbbWrAddr = r_bm_addr;
  assign io_bus.sched2bm_rbbWrDin  = r_bm_din;
  assign o_dbg_state               = r_state;

endmodule

// File: tb/tb_pe_array_sched.sv
// Directed bench for pe_array_sched: batch scheduling, done accounting, error
// flag, round-robin write arbitration and asynchronous reset.
module tb_pe_array_sched;
  localparam int NP  = 4;
  localparam int PIW = 2;
  localparam int DW  = 32;
  localparam int AW  = 12;
  localparam int JW  = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] dbg_state;

  always #5 clk = ~clk;

  pe_array_sched_if #(.NUM_PE(NP), .PE_ID_WIDTH(PIW), .RBB_DATA_WIDTH(DW),
                      .RBB_ADDR_WIDTH(AW), .JOB_CNT_WIDTH(JW)) bus ();

  pe_array_sched #(.NUM_PE(NP), .PE_ID_WIDTH(PIW), .RBB_DATA_WIDTH(DW),
                   .RBB_ADDR_WIDTH(AW), .JOB_CNT_WIDTH(JW)) dut (
    .clk         (clk),
    .reset       (reset),
    .io_bus      (bus),
    .o_dbg_state (dbg_state)
  );

  int          n_checks = 0;
  int          n_errors = 0;
  logic [15:0] exp_q[$];

  typedef struct {
    logic [NP-1:0]     en;
    logic [NP*AW-1:0]  addr;
    logic [NP-1:0]     exp_gnt;
    logic              exp_en;
    logic [PIW+AW-1:0] exp_addr;
    logic [DW-1:0]     exp_din;
  } arb_vec_t;

  arb_vec_t vecs[18];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive_edge();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [NP*AW-1:0] pack4(input logic [AW-1:0] a0, a1, a2, a3);
    return {a3, a2, a1, a0};
  endfunction

  function automatic arb_vec_t mk(input logic [NP-1:0] en, input logic [NP*AW-1:0] addr,
                                  input logic [NP-1:0] g, input logic e,
                                  input logic [PIW+AW-1:0] a, input logic [DW-1:0] d);
    arb_vec_t v;
    v.en = en; v.addr = addr; v.exp_gnt = g; v.exp_en = e; v.exp_addr = a; v.exp_din = d;
    return v;
  endfunction

  // Starts a batch, models each PE as returning done lat cycles after its start,
  // and checks every start (cycle and PE) against exp_q plus the done timing.
  task automatic run_batch(input string tag, input int nj, input int l0, input int l1,
                           input int l2, input int l3, input int restart_cyc,
                           input int exp_done_cyc);
    int            lat[NP];
    int            cnt[NP];
    int            done_cyc;
    int            busy_bad;
    logic          busy_at_done;
    logic          err_at_done;
    logic [NP-1:0] dv;
    lat = '{l0, l1, l2, l3};
    cnt = '{default: 0};
    done_cyc = -1;
    busy_bad = 0;
    busy_at_done = 1'b1;
    err_at_done  = 1'b1;
    drive_edge();
    bus.host_start    = 1'b1;
    bus.host_num_jobs = JW'(nj);
    bus.pe2sched_done = '0;
    @(negedge clk);
    for (int c = 1; c <= 60 && done_cyc < 0; c++) begin
      drive_edge();
      bus.host_start    = (c == restart_cyc);
      bus.host_num_jobs = (c == restart_cyc) ? JW'(1) : JW'(nj);
      dv = '0;
      for (int i = 0; i < NP; i++) begin
        if (cnt[i] > 0) begin
          cnt[i]--;
          if (cnt[i] == 0) dv[i] = 1'b1;
        end
      end
      bus.pe2sched_done = dv;
      @(negedge clk);
      for (int i = 0; i < NP; i++) begin
        if (bus.sched2pe_start[i]) begin
          cnt[i] = lat[i];
          if (exp_q.size() == 0) check({tag, "_extra_start"}, 64'(c * 16 + i), 64'hFFFF);
          else check({tag, "_start"}, 64'(c * 16 + i), 64'(exp_q.pop_front()));
        end
      end
      if (c == 1) begin
        check({tag, "_busy_c1"}, 64'(bus.host_busy), 64'd1);
        check({tag, "_err_c1"}, 64'(bus.host_err), 64'd0);
      end
      if (bus.host_done) begin
        done_cyc     = c;
        busy_at_done = bus.host_busy;
        err_at_done  = bus.host_err;
      end else if (!bus.host_busy) begin
        busy_bad++;
      end
    end
    check({tag, "_done_cycle"}, 64'(done_cyc), 64'(exp_done_cyc));
    check({tag, "_missing_starts"}, 64'(exp_q.size()), 64'd0);
    check({tag, "_busy_gap"}, 64'(busy_bad), 64'd0);
    check({tag, "_busy_at_done"}, 64'(busy_at_done), 64'd0);
    check({tag, "_err_at_done"}, 64'(err_at_done), 64'd0);
    drive_edge();
    bus.host_start    = 1'b0;
    bus.pe2sched_done = '0;
    @(negedge clk);
    check({tag, "_done_one_cycle"}, 64'(bus.host_done), 64'd0);
    check({tag, "_state_idle"}, 64'(dbg_state), 64'd0);
    exp_q.delete();
  endtask

  initial begin
    int n_done;
    logic [NP*AW-1:0] a5;
    reset             = 1'b1;
    bus.host_start    = 1'b0;
    bus.host_num_jobs = '0;
    bus.pe2sched_done = '0;
    bus.pe_rbbWrEn    = '0;
    bus.pe_rbbWrAddr  = '0;
    bus.pe_rbbWrDin   = {32'hD000_0003, 32'hD000_0002, 32'hD000_0001, 32'hD000_0000};

    a5 = pack4(12'h005, 12'h005, 12'h005, 12'h005);
    vecs[0]  = mk(4'hF, a5, 4'b0001, 1'b0, 14'h0000, 32'h0);
    vecs[1]  = mk(4'hF, a5, 4'b0010, 1'b1, 14'h0005, 32'hD000_0000);
    vecs[2]  = mk(4'hF, a5, 4'b0100, 1'b1, 14'h1005, 32'hD000_0001);
    vecs[3]  = mk(4'hF, a5, 4'b1000, 1'b1, 14'h2005, 32'hD000_0002);
    vecs[4]  = mk(4'hF, a5, 4'b0001, 1'b1, 14'h3005, 32'hD000_0003);
    vecs[5]  = mk(4'hF, a5, 4'b0010, 1'b1, 14'h0005, 32'hD000_0000);
    vecs[6]  = mk(4'hF, a5, 4'b0100, 1'b1, 14'h1005, 32'hD000_0001);
    vecs[7]  = mk(4'hF, a5, 4'b1000, 1'b1, 14'h2005, 32'hD000_0002);
    vecs[8]  = mk(4'h0, '0, 4'b0000, 1'b1, 14'h3005, 32'hD000_0003);
    vecs[9]  = mk(4'h0, '0, 4'b0000, 1'b0, 14'h0000, 32'h0);
    vecs[10] = mk(4'b1010, pack4(12'h000, 12'h0AB, 12'h000, 12'hFFF), 4'b0010, 1'b0, 14'h0000, 32'h0);
    vecs[11] = mk(4'b1000, pack4(12'h000, 12'h0AB, 12'h000, 12'hFFF), 4'b1000, 1'b1, 14'h10AB, 32'hD000_0001);
    vecs[12] = mk(4'b0101, pack4(12'h123, 12'h000, 12'h456, 12'h000), 4'b0001, 1'b1, 14'h3FFF, 32'hD000_0003);
    vecs[13] = mk(4'b0100, pack4(12'h123, 12'h000, 12'h456, 12'h000), 4'b0100, 1'b1, 14'h0123, 32'hD000_0000);
    vecs[14] = mk(4'b1001, pack4(12'h001, 12'h000, 12'h000, 12'h7E0), 4'b1000, 1'b1, 14'h2456, 32'hD000_0002);
    vecs[15] = mk(4'b0001, pack4(12'h001, 12'h000, 12'h000, 12'h7E0), 4'b0001, 1'b1, 14'h37E0, 32'hD000_0003);
    vecs[16] = mk(4'h0, '0, 4'b0000, 1'b1, 14'h0001, 32'hD000_0000);
    vecs[17] = mk(4'h0, '0, 4'b0000, 1'b0, 14'h0000, 32'h0);

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 64'(bus.host_busy), 64'd0);
    check("rst_done", 64'(bus.host_done), 64'd0);
    check("rst_err", 64'(bus.host_err), 64'd0);
    check("rst_start", 64'(bus.sched2pe_start), 64'd0);
    check("rst_gnt", 64'(bus.pe_rbbWrGnt), 64'd0);
    check("rst_bm_en", 64'(bus.sched2bm_rbbWrEn), 64'd0);
    check("rst_bm_addr", 64'(bus.sched2bm_rbbWrAddr), 64'd0);
    check("rst_bm_din", 64'(bus.sched2bm_rbbWrDin), 64'd0);
    check("rst_state", 64'(dbg_state), 64'd0);
    drive_edge();
    reset = 1'b0;

    // Zero-job batch: busy for one cycle, done two cycles after start
    drive_edge();
    bus.host_start = 1'b1;
    bus.host_num_jobs = '0;
    @(negedge clk);
    check("j0_busy_c0", 64'(bus.host_busy), 64'd0);
    drive_edge();
    bus.host_start = 1'b0;
    @(negedge clk);
    check("j0_busy_c1", 64'(bus.host_busy), 64'd1);
    check("j0_done_c1", 64'(bus.host_done), 64'd0);
    check("j0_state_c1", 64'(dbg_state), 64'd3);
    drive_edge();
    @(negedge clk);
    check("j0_busy_c2", 64'(bus.host_busy), 64'd0);
    check("j0_done_c2", 64'(bus.host_done), 64'd1);
    check("j0_start_c2", 64'(bus.sched2pe_start), 64'd0);
    drive_edge();
    @(negedge clk);
    check("j0_done_c3", 64'(bus.host_done), 64'd0);

    // Six jobs, latency 10, with an ignored host_start while dispatching
    exp_q = '{16'h010, 16'h021, 16'h032, 16'h043, 16'h0C0, 16'h0D1};
    run_batch("six", 6, 10, 10, 10, 10, 5, 26);

    // Done from an idle PE is a protocol error until the next start
    drive_edge();
    bus.pe2sched_done = 4'b0100;
    @(negedge clk);
    check("err_before", 64'(bus.host_err), 64'd0);
    drive_edge();
    bus.pe2sched_done = '0;
    @(negedge clk);
    check("err_set", 64'(bus.host_err), 64'd1);
    drive_edge();
    @(negedge clk);
    check("err_sticky", 64'(bus.host_err), 64'd1);
    exp_q = '{16'h010};
    run_batch("one", 1, 3, 3, 3, 3, -1, 7);

    // PE1 finishes in the cycle PE3 is dispatched; it is reused one cycle later
    exp_q = '{16'h010, 16'h021, 16'h032, 16'h043, 16'h051};
    run_batch("reuse", 5, 10, 2, 10, 10, -1, 17);

    // All four PEs finish in the same cycle
    exp_q = '{16'h010, 16'h021, 16'h032, 16'h043};
    run_batch("coinc", 4, 4, 3, 2, 1, -1, 8);

    // Round-robin write arbitration, table driven
    foreach (vecs[v]) begin
      drive_edge();
      bus.pe_rbbWrEn   = vecs[v].en;
      bus.pe_rbbWrAddr = vecs[v].addr;
      @(negedge clk);
      check($sformatf("arb%0d_gnt", v), 64'(bus.pe_rbbWrGnt), 64'(vecs[v].exp_gnt));
      check($sformatf("arb%0d_bm_en", v), 64'(bus.sched2bm_rbbWrEn), 64'(vecs[v].exp_en));
      if (vecs[v].exp_en) begin
        check($sformatf("arb%0d_bm_addr", v), 64'(bus.sched2bm_rbbWrAddr), 64'(vecs[v].exp_addr));
        check($sformatf("arb%0d_bm_din", v), 64'(bus.sched2bm_rbbWrDin), 64'(vecs[v].exp_din));
      end
    end

    // Reset during dispatch with two jobs left
    drive_edge();
    bus.host_start = 1'b1;
    bus.host_num_jobs = JW'(4);
    @(negedge clk);
    drive_edge();
    bus.host_start = 1'b0;
    @(negedge clk);
    check("ab_start_c1", 64'(bus.sched2pe_start), 64'b0001);
    drive_edge();
    @(negedge clk);
    check("ab_start_c2", 64'(bus.sched2pe_start), 64'b0010);
    drive_edge();
    @(negedge clk);
    check("ab_start_c3", 64'(bus.sched2pe_start), 64'b0100);
    check("ab_busy_c3", 64'(bus.host_busy), 64'd1);
    #1 reset = 1'b1;
    #1;
    check("ab_async_start", 64'(bus.sched2pe_start), 64'd0);
    check("ab_async_busy", 64'(bus.host_busy), 64'd0);
    check("ab_async_done", 64'(bus.host_done), 64'd0);
    check("ab_async_state", 64'(dbg_state), 64'd0);
    drive_edge();
    drive_edge();
    reset = 1'b0;
    n_done = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (bus.host_done) n_done++;
    end
    check("ab_no_done", 64'(n_done), 64'd0);
    exp_q = '{16'h010, 16'h021};
    run_batch("post", 2, 5, 5, 5, 5, -1, 10);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
